arbiter_grant_ctrl: RTL and testbench

Sequential wrapper for the 3-request arbiter next-state logic. Synchronises raw requests into the X2/X1/X0 vector, holds the Q1/Q0 state register fed back to the arbiter, and enforces grant tenure. A tenure ends on DONE handshake, on request withdrawal, or on a hold-timeout, and is always followed by one idle gap. Decodes the state into one-hot grants for the downstream shared resource.

---
 rtl/arbiter_grant_ctrl.sv | 129 ++++++++++++
 tb/tb_arbiter_grant_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_grant_ctrl.sv
// Sequential wrapper around the 3-request arbiter next-state logic: request
// synchroniser, Q1/Q0 state register, grant tenure control and grant decode.
module arbiter_grant_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_W      = 8,
    parameter int MAX_HOLD    = 200
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ2,
    input  logic REQ1,
    input  logic REQ0,
    input  logic Qp1,
    input  logic Qp0,
    input  logic DONE,
    output logic X2,
    output logic X1,
    output logic X0,
    output logic Q1,
    output logic Q0,
    output logic GNT2,
    output logic GNT1,
    output logic GNT0,
    output logic BUSY,
    output logic TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HOLD    = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);

    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    state_t                      state_q, state_d;
    logic [1:0]                  q_q, q_d;
    logic [HOLD_W-1:0]           cnt_q, cnt_d;
    logic                        timeout_q, timeout_d;
    logic [2:0]                  x;
    logic                        granted_req;

    always_comb begin
        sync_d[0] = {REQ2, REQ1, REQ0};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign x = sync_q[SYNC_STAGES-1];

    // Synchronised request of whichever master currently owns the grant.
    always_comb begin
        granted_req = 1'b0;
        case (q_q)
            2'b01:   granted_req = x[2];
            2'b10:   granted_req = x[1];
            2'b11:   granted_req = x[0];
            default: granted_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ({Qp1, Qp0} != 2'b00) begin
                    q_d     = {Qp1, Qp0};
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // DONE outranks withdrawal, which outranks the hold timeout.
                if (DONE) begin
                    q_d     = 2'b00;
                    state_d = ST_RELEASE;
                end else if (!granted_req) begin
                    q_d     = 2'b00;
                    state_d = ST_RELEASE;
                end else if (TIMEOUT_EN && (cnt_q == HOLD_LAST)) begin
                    q_d       = 2'b00;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                q_d     = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q    <= '0;
            state_q   <= ST_IDLE;
            q_q       <= 2'b00;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign {X2, X1, X0} = x;
    assign {Q1, Q0}     = q_q;
    assign GNT2         = (state_q == ST_HOLD) && (q_q == 2'b01);
    assign GNT1         = (state_q == ST_HOLD) && (q_q == 2'b10);
    assign GNT0         = (state_q == ST_HOLD) && (q_q == 2'b11);
    assign BUSY         = (state_q == ST_HOLD) || (state_q == ST_RELEASE);
    assign TIMEOUT      = timeout_q;

endmodule

// File: tb/tb_arbiter_grant_ctrl.sv
// Directed bench for arbiter_grant_ctrl closed-loop with a fixed-priority
// arbiter model (master 0 > master 1 > master 2), SYNC_STAGES=2, MAX_HOLD=4.
module tb_arbiter_grant_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic REQ2, REQ1, REQ0;
    logic Qp1, Qp0;
    logic DONE;
    logic X2, X1, X0;
    logic Q1, Q0;
    logic GNT2, GNT1, GNT0;
    logic BUSY, TIMEOUT;

    int totalChecks = 0;
    int badChecks   = 0;

    logic [2:0] gnt;
    logic [1:0] q;
    logic [2:0] x;
    logic [1:0] qp;

    assign gnt = {GNT2, GNT1, GNT0};
    assign q   = {Q1, Q0};
    assign x   = {X2, X1, X0};

    arbiter_grant_ctrl #(
        .SYNC_STAGES(2),
        .HOLD_W     (8),
        .MAX_HOLD   (4)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ2   (REQ2),
        .REQ1   (REQ1),
        .REQ0   (REQ0),
        .Qp1    (Qp1),
        .Qp0    (Qp0),
        .DONE   (DONE),
        .X2     (X2),
        .X1     (X1),
        .X0     (X0),
        .Q1     (Q1),
        .Q0     (Q0),
        .GNT2   (GNT2),
        .GNT1   (GNT1),
        .GNT0   (GNT0),
        .BUSY   (BUSY),
        .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Stand-in for the team arbiter next-state logic.
    always_comb begin
        qp = 2'b00;
        if (x[0])      qp = 2'b11;
        else if (x[1]) qp = 2'b10;
        else if (x[2]) qp = 2'b01;
    end
    assign {Qp1, Qp0} = qp;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic done);
        {REQ2, REQ1, REQ0} = req;
        DONE               = done;
    endtask

    task automatic doReset();
        RST = 1'b1;
        applyStimulus(3'b000, 1'b0);
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        // Reset with all requests raised
        RST = 1'b1;
        applyStimulus(3'b111, 1'b0);
        repeat (3) tick();
        checkOutput("rst_x",   8'(x),       8'h0);
        checkOutput("rst_q",   8'(q),       8'h0);
        checkOutput("rst_gnt", 8'(gnt),     8'h0);
        checkOutput("rst_bsy", 8'(BUSY),    8'h0);
        checkOutput("rst_to",  8'(TIMEOUT), 8'h0);
        RST = 1'b0;
        applyStimulus(3'b000, 1'b0);
        repeat (5) tick();
        checkOutput("idle_q",   8'(q),    8'h0);
        checkOutput("idle_gnt", 8'(gnt),  8'h0);
        checkOutput("idle_bsy", 8'(BUSY), 8'h0);

        // Single request on master 0, DONE on the second HOLD cycle
        doReset();
        applyStimulus(3'b001, 1'b0);
        tick();
        checkOutput("s_x_e1", 8'(x), 8'h0);
        tick();
        checkOutput("s_x_e2",   8'(x),   8'h1);
        checkOutput("s_gnt_e2", 8'(gnt), 8'h0);
        tick();
        checkOutput("s_q_e3",   8'(q),    8'h3);
        checkOutput("s_gnt_e3", 8'(gnt),  8'h1);
        checkOutput("s_bsy_e3", 8'(BUSY), 8'h1);
        tick();
        applyStimulus(3'b000, 1'b1);
        tick();
        applyStimulus(3'b000, 1'b0);
        checkOutput("s_gnt_rel", 8'(gnt),     8'h0);
        checkOutput("s_q_rel",   8'(q),       8'h0);
        checkOutput("s_bsy_rel", 8'(BUSY),    8'h1);
        checkOutput("s_to_rel",  8'(TIMEOUT), 8'h0);
        tick();
        checkOutput("s_bsy_idle", 8'(BUSY), 8'h0);
        tick();
        checkOutput("s_gnt_idle", 8'(gnt), 8'h0);

        // DONE in IDLE is ignored
        applyStimulus(3'b000, 1'b1);
        tick();
        tick();
        applyStimulus(3'b000, 1'b0);
        checkOutput("done_idle_bsy", 8'(BUSY), 8'h0);

        // Timeout on master 1, then re-grant after one gap cycle
        doReset();
        applyStimulus(3'b010, 1'b0);
        tick();
        tick();
        checkOutput("t_x_e2", 8'(x), 8'h2);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t_gnt_h%0d", i), 8'(gnt),     8'h2);
            checkOutput($sformatf("t_to_h%0d", i),  8'(TIMEOUT), 8'h0);
        end
        tick();
        checkOutput("t_gnt_rel", 8'(gnt),     8'h0);
        checkOutput("t_to_rel",  8'(TIMEOUT), 8'h1);
        checkOutput("t_q_rel",   8'(q),       8'h0);
        tick();
        checkOutput("t_to_gap",  8'(TIMEOUT), 8'h0);
        checkOutput("t_bsy_gap", 8'(BUSY),    8'h0);
        tick();
        checkOutput("t_regrant", 8'(gnt), 8'h2);

        // Withdrawal of master 2
        doReset();
        applyStimulus(3'b100, 1'b0);
        repeat (3) tick();
        checkOutput("w_gnt_on", 8'(gnt), 8'h4);
        applyStimulus(3'b000, 1'b0);
        tick();
        tick();
        checkOutput("w_gnt_hold", 8'(gnt), 8'h4);
        tick();
        checkOutput("w_gnt_off", 8'(gnt),     8'h0);
        checkOutput("w_to",      8'(TIMEOUT), 8'h0);
        checkOutput("w_bsy",     8'(BUSY),    8'h1);

        // DONE coincides with the last allowed HOLD cycle
        doReset();
        applyStimulus(3'b001, 1'b0);
        repeat (6) tick();
        checkOutput("c_gnt_last", 8'(gnt), 8'h1);
        applyStimulus(3'b001, 1'b1);
        tick();
        applyStimulus(3'b001, 1'b0);
        checkOutput("c_to",  8'(TIMEOUT), 8'h0);
        checkOutput("c_gnt", 8'(gnt),     8'h0);
        checkOutput("c_bsy", 8'(BUSY),    8'h1);
        tick();
        checkOutput("c_to_late", 8'(TIMEOUT), 8'h0);

        // Reset during HOLD
        doReset();
        applyStimulus(3'b001, 1'b0);
        repeat (4) tick();
        checkOutput("r_gnt_pre", 8'(gnt), 8'h1);
        RST = 1'b1;
        tick();
        checkOutput("r_gnt", 8'(gnt),     8'h0);
        checkOutput("r_q",   8'(q),       8'h0);
        checkOutput("r_bsy", 8'(BUSY),    8'h0);
        checkOutput("r_to",  8'(TIMEOUT), 8'h0);
        RST = 1'b0;

        // Contention: all three requesting, DONE on each third HOLD cycle
        doReset();
        applyStimulus(3'b111, 1'b0);
        repeat (3) tick();
        checkOutput("k_gnt0", 8'(gnt), 8'h1);
        tick();
        tick();
        checkOutput("k_gnt0_h3", 8'(gnt), 8'h1);
        applyStimulus(3'b110, 1'b1);
        tick();
        applyStimulus(3'b110, 1'b0);
        checkOutput("k_rel1_gnt", 8'(gnt),  8'h0);
        checkOutput("k_rel1_bsy", 8'(BUSY), 8'h1);
        tick();
        checkOutput("k_gap1_gnt", 8'(gnt),  8'h0);
        checkOutput("k_gap1_bsy", 8'(BUSY), 8'h0);
        tick();
        checkOutput("k_gnt1",   8'(gnt), 8'h2);
        checkOutput("k_q1",     8'(q),   8'h2);
        checkOutput("k_onehot", 8'($countones(gnt)), 8'h1);
        tick();
        tick();
        applyStimulus(3'b100, 1'b1);
        tick();
        applyStimulus(3'b100, 1'b0);
        checkOutput("k_rel2_gnt", 8'(gnt),  8'h0);
        checkOutput("k_rel2_bsy", 8'(BUSY), 8'h1);
        tick();
        checkOutput("k_gap2_gnt", 8'(gnt), 8'h0);
        tick();
        checkOutput("k_gnt2", 8'(gnt), 8'h4);
        checkOutput("k_q2",   8'(q),   8'h1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
